// File: rtl/udp_reg_master_pkg.sv
// Shared definitions for the UDP register ring master: field widths,
// the no-response fill value and the master FSM encoding.
package udp_reg_master_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] NO_RESPONSE_DATA = 32'hdead_beef;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } master_state_e;

endpackage

// File: rtl/udp_reg_master_if.sv
// Register ring word bundle: launch word towards the first ring stage and
// return word coming back from the last ring stage.
interface udp_reg_master_if
    import udp_reg_master_pkg::*;
#(
    parameter int UDP_REG_SRC_WIDTH = 2
);
    logic                           reg_req_out;
    logic                           reg_ack_out;
    logic                           reg_rd_wr_L_out;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

    logic                           reg_req_in;
    logic                           reg_ack_in;
    logic                           reg_rd_wr_L_in;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;

    modport master (
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out,
               reg_addr_out, reg_data_out, reg_src_out,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in,
               reg_addr_in, reg_data_in, reg_src_in
    );

    modport slave (
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out,
               reg_addr_out, reg_data_out, reg_src_out,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in,
               reg_addr_in, reg_data_in, reg_src_in
    );

endinterface

// File: rtl/udp_reg_master.sv
// Initiator and terminator of the UDP register ring: issues one host
// transaction at a time and completes it when its own word returns.
module udp_reg_master
    import udp_reg_master_pkg::*;
#(
    parameter int                           UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = {UDP_REG_SRC_WIDTH{1'b0}},
    parameter int                           TIMEOUT           = 127
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           host_req,
    input  logic                           host_rd_wr_L,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  host_addr,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] host_wr_data,
    output logic                           host_ack,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] host_rd_data,
    output logic                           host_err,
    udp_reg_master_if.master               ring
);

    localparam int                  TIMER_W   = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_MAX = TIMER_W'(TIMEOUT);

    master_state_e                  state_r;
    logic [TIMER_W-1:0]             timer_r;
    logic [UDP_REG_ADDR_WIDTH-1:0]  addr_r;
    logic                           rd_wr_l_r;
    logic [CPCI_NF2_DATA_WIDTH-1:0] wr_data_r;
    logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_data_r;
    logic                           rsp_err_r;
    logic                           match_s;
    logic                           unused_ring_s;

    // The return word's rd_wr_L plays no part in matching.
    assign unused_ring_s = ring.reg_rd_wr_L_in;

    // Detect our own word coming back around the ring.
    always_comb begin
        match_s = 1'b0;
        if (ring.reg_req_in && (ring.reg_src_in == SRC_ID) && (ring.reg_addr_in == addr_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Transaction FSM, wait timer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r              <= ST_IDLE;
            timer_r              <= {TIMER_W{1'b0}};
            addr_r               <= {UDP_REG_ADDR_WIDTH{1'b0}};
            rd_wr_l_r            <= 1'b0;
            wr_data_r            <= {CPCI_NF2_DATA_WIDTH{1'b0}};
            rsp_data_r           <= {CPCI_NF2_DATA_WIDTH{1'b0}};
            rsp_err_r            <= 1'b0;
            host_ack             <= 1'b0;
            host_rd_data         <= {CPCI_NF2_DATA_WIDTH{1'b0}};
            host_err             <= 1'b0;
            ring.reg_req_out     <= 1'b0;
            ring.reg_ack_out     <= 1'b0;
            ring.reg_rd_wr_L_out <= 1'b0;
            ring.reg_addr_out    <= {UDP_REG_ADDR_WIDTH{1'b0}};
            ring.reg_data_out    <= {CPCI_NF2_DATA_WIDTH{1'b0}};
            ring.reg_src_out     <= {UDP_REG_SRC_WIDTH{1'b0}};
        end else begin
            // Ring word and ack are pulses; they fall back to zero unless set below.
            host_ack             <= 1'b0;
            host_err             <= 1'b0;
            ring.reg_req_out     <= 1'b0;
            ring.reg_ack_out     <= 1'b0;
            ring.reg_rd_wr_L_out <= 1'b0;
            ring.reg_addr_out    <= {UDP_REG_ADDR_WIDTH{1'b0}};
            ring.reg_data_out    <= {CPCI_NF2_DATA_WIDTH{1'b0}};
            ring.reg_src_out     <= {UDP_REG_SRC_WIDTH{1'b0}};

            case (state_r)
                ST_IDLE: begin
                    if (host_req) begin
                        addr_r    <= host_addr;
                        rd_wr_l_r <= host_rd_wr_L;
                        wr_data_r <= host_rd_wr_L ? {CPCI_NF2_DATA_WIDTH{1'b0}} : host_wr_data;
                        state_r   <= ST_ISSUE;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    ring.reg_req_out     <= 1'b1;
                    ring.reg_ack_out     <= 1'b0;
                    ring.reg_rd_wr_L_out <= rd_wr_l_r;
                    ring.reg_addr_out    <= addr_r;
                    ring.reg_data_out    <= wr_data_r;
                    ring.reg_src_out     <= SRC_ID;
                    timer_r              <= {TIMER_W{1'b0}};
                    state_r              <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A return in the timeout cycle still counts as answered.
                    if (match_s) begin
                        rsp_data_r <= ring.reg_ack_in ? ring.reg_data_in : NO_RESPONSE_DATA;
                        rsp_err_r  <= ~ring.reg_ack_in;
                        state_r    <= ST_DONE;
                    end else if (timer_r >= TIMER_MAX) begin
                        rsp_data_r <= NO_RESPONSE_DATA;
                        rsp_err_r  <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        timer_r    <= timer_r + TIMER_W'(1'b1);
                        state_r    <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    host_ack     <= 1'b1;
                    host_rd_data <= rsp_data_r;
                    host_err     <= rsp_err_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
